led_wr_arbiter: RTL and testbench
=================================

# led_wr_arbiter

Write-port controller for the 8x8 LED display RAM. It shares the single RAM write port between the light-pen path and a pattern loader, and runs a self-timed full-screen clear sweep. It sits between the pen/state logic and the LED RAM. The scan driver keeps sole ownership of the RAM read side; this block only drives the write side.

## Interface
Parameters:
- ADDR_W, 3: row/column address width; the screen is 2^ADDR_W x 2^ADDR_W.
- DATA_W, 4: RAM word width, {on, g, r, rsvd}.
- CLR_DATA, 4'b0000: word written by the clear sweep.

Ports (one clock; reset is synchronous and active-high):
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- clr_start, input, 1: request a full-screen clear; level sampled in IDLE.
- clr_busy, output, 1: high while a sweep is in progress.
- clr_done, output, 1: one-cycle pulse after the last sweep write.
- pen_req, input, 1: light-pen write request.
- pen_row, input, ADDR_W: light-pen row address.
- pen_col, input, ADDR_W: light-pen column address.
- pen_data, input, DATA_W: light-pen write data.
- pen_gnt, output, 1: one-cycle grant to the light pen.
- ld_req, input, 1: pattern-loader write request.
- ld_row, input, ADDR_W: pattern-loader row address.
- ld_col, input, ADDR_W: pattern-loader column address.
- ld_data, input, DATA_W: pattern-loader write data.
- ld_gnt, output, 1: one-cycle grant to the pattern loader.
- ram_we, output, 1: registered RAM write enable.
- ram_row, output, ADDR_W: registered RAM row address.
- ram_col, output, ADDR_W: registered RAM column address.
- ram_wdata, output, DATA_W: registered RAM write data.
- last_row, output, ADDR_W: row of the most recent requester write (clear writes excluded).
- last_col, output, ADDR_W: column of the most recent requester write (clear writes excluded).

## Operation
- FSM states: IDLE, WRITE, CLEAR.
- IDLE decisions, in priority order:
  - clr_start=1: go to CLEAR, set cnt=0. Any request is left pending and no grant is issued.
  - Otherwise, if one or more requests are present: arbitrate (see Configuration), capture the winner's row/col/data into ram_* registers, go to WRITE.
  - Otherwise: stay in IDLE.
- WRITE lasts exactly one cycle:
  - ram_we=1 and the winner's gnt=1.
  - last_row/last_col update to the written address.
  - Always returns to IDLE, which gives a turnaround cycle.
- CLEAR:
  - Each cycle: ram_we=1, ram_row=cnt[2*ADDR_W-1:ADDR_W], ram_col=cnt[ADDR_W-1:0], ram_wdata=CLR_DATA; cnt increments.
  - Sweep runs 2^(2*ADDR_W) writes (64 at default), row-major starting at (0,0).
  - After the write at cnt = all-ones: return to IDLE and pulse clr_done for one cycle, coinciding with the first IDLE cycle.
  - clr_busy=1 for the entire CLEAR state.
  - clr_start is ignored while in CLEAR.
  - No grants are issued during CLEAR; pending requests are serviced after it.
- Requester handshake:
  - Hold req and payload stable until gnt is seen.
  - Deassert req, or present a new payload, at the clock edge that ends the gnt cycle.
  - A req still high in the following IDLE cycle is treated as a new request.
- Payload changing while a request is pending and not yet granted: whatever is present in the IDLE sampling cycle is written.
- ram_we=0 in every state other than WRITE and CLEAR.

## Timing
- Reset values: state=IDLE, cnt=0. All of the following are 0: ram_we, ram_row, ram_col, ram_wdata, pen_gnt, ld_gnt, clr_busy, clr_done, last_row, last_col, rr_ptr.
- Requester write latency: request sampled in IDLE at cycle N; ram_we and gnt are high in cycle N+1. All outputs are registered.
- Throughput per requester: at most one write every 2 cycles.
- Clear timing: clr_start sampled at cycle N; sweep writes occupy cycles N+1 .. N+64; clr_done pulses at N+65.
- rst asserted mid-sweep or mid-WRITE: all outputs return to reset values at the next edge. No clr_done is issued and the sweep is not resumed.
- clr_start and a request in the same IDLE cycle: the clear wins; the request is granted no earlier than 2 cycles after clr_done.

## Configuration
- LED_ARB_RR_EN defined:
  - Round-robin between pen and loader when both request.
  - rr_ptr points at the favoured requester and resets to pen.
  - After any requester grant, rr_ptr moves to the other requester.
  - With only one requester active, that requester is granted regardless of rr_ptr.
- LED_ARB_RR_EN undefined:
  - Fixed priority, pen over loader.
  - No rr_ptr register exists.

## Test plan
- Reset, then a single pen_req with row=3, col=5, data=4'b1010: ram_we is high exactly one cycle later with ram_row=3, ram_col=5, ram_wdata=4'hA; pen_gnt is high in the same cycle; last_row/last_col read 3/5.
- clr_start pulse from IDLE: 64 consecutive ram_we cycles covering addresses (0,0)..(7,7) in order with data 0; clr_busy is high for all 64 cycles; clr_done pulses once at cycle 65.
- pen_req held during a clear: no pen_gnt until after clr_done; the pen write then appears 2 cycles after clr_done; last_row/last_col do not change during the sweep.
- pen_req and ld_req both held high for 8 grants:
  - With LED_ARB_RR_EN: grants alternate pen, ld, pen, ld..., one grant every 2 cycles.
  - Without LED_ARB_RR_EN: all 8 grants go to pen.
- rst asserted at sweep write 20: the next cycle shows ram_we=0, clr_busy=0, and no clr_done. A fresh clr_start after reset restarts the sweep at (0,0).
- ld_req held continuously: ld_gnt is high on alternate cycles only; ram_we is never high in two consecutive cycles outside CLEAR.

Source files
------------

// File: rtl/led_wr_arbiter.sv
// Write-port controller for the 8x8 LED RAM: arbitrates pen/loader writes and runs a clear sweep.
// Optional feature: define LED_ARB_RR_EN for round-robin arbitration (default is pen-over-loader priority).
module led_wr_arbiter #(
  parameter int                ADDR_W   = 3,
  parameter int                DATA_W   = 4,
  parameter logic [DATA_W-1:0] CLR_DATA = 4'b0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic              pen_req,
  input  logic [ADDR_W-1:0] pen_row,
  input  logic [ADDR_W-1:0] pen_col,
  input  logic [DATA_W-1:0] pen_data,
  output logic              pen_gnt,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_row,
  input  logic [ADDR_W-1:0] ld_col,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_gnt,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_row,
  output logic [ADDR_W-1:0] ram_col,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [ADDR_W-1:0] last_row,
  output logic [ADDR_W-1:0] last_col
);

  localparam int CNT_W = 2 * ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic               ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]  ram_row_q, ram_row_d;
  logic [ADDR_W-1:0]  ram_col_q, ram_col_d;
  logic [DATA_W-1:0]  ram_wdata_q, ram_wdata_d;
  logic               pen_gnt_q, pen_gnt_d;
  logic               ld_gnt_q, ld_gnt_d;
  logic               clr_busy_q, clr_busy_d;
  logic               clr_done_q, clr_done_d;
  logic [ADDR_W-1:0]  last_row_q, last_row_d;
  logic [ADDR_W-1:0]  last_col_q, last_col_d;
  logic               sel_ld_s;
  logic               any_req_s;
  logic [ADDR_W-1:0]  win_row_s;
  logic [ADDR_W-1:0]  win_col_s;
  logic [DATA_W-1:0]  win_data_s;

`ifdef LED_ARB_RR_EN
  // rr_ptr: 0 favours the pen, 1 favours the loader
  logic rr_ptr_q, rr_ptr_d;

  // Winner selection: round-robin when both request
  always_comb begin
    sel_ld_s = ld_req & (~pen_req | rr_ptr_q);
  end
`else
  // Winner selection: pen has fixed priority over the loader
  always_comb begin
    sel_ld_s = ld_req & ~pen_req;
  end
`endif

  // Winner payload mux and sweep counter increment
  always_comb begin
    any_req_s  = pen_req | ld_req;
    win_row_s  = sel_ld_s ? ld_row  : pen_row;
    win_col_s  = sel_ld_s ? ld_col  : pen_col;
    win_data_s = sel_ld_s ? ld_data : pen_data;
    cnt_inc_s  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Next-state and next-output computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ram_we_d    = 1'b0;
    ram_row_d   = ram_row_q;
    ram_col_d   = ram_col_q;
    ram_wdata_d = ram_wdata_q;
    pen_gnt_d   = 1'b0;
    ld_gnt_d    = 1'b0;
    clr_busy_d  = 1'b0;
    clr_done_d  = 1'b0;
    last_row_d  = last_row_q;
    last_col_d  = last_col_q;
`ifdef LED_ARB_RR_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d     = ST_CLEAR;
          cnt_d       = {CNT_W{1'b0}};
          ram_we_d    = 1'b1;
          ram_row_d   = {ADDR_W{1'b0}};
          ram_col_d   = {ADDR_W{1'b0}};
          ram_wdata_d = CLR_DATA;
          clr_busy_d  = 1'b1;
        end else if (any_req_s && !clr_done_q) begin
          // The clr_done cycle is a turnaround: requests wait one more cycle
          state_d     = ST_WRITE;
          ram_we_d    = 1'b1;
          ram_row_d   = win_row_s;
          ram_col_d   = win_col_s;
          ram_wdata_d = win_data_s;
          pen_gnt_d   = ~sel_ld_s;
          ld_gnt_d    = sel_ld_s;
          last_row_d  = win_row_s;
          last_col_d  = win_col_s;
`ifdef LED_ARB_RR_EN
          rr_ptr_d    = ~sel_ld_s;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
      end
      ST_CLEAR: begin
        if (cnt_q == {CNT_W{1'b1}}) begin
          state_d    = ST_IDLE;
          clr_done_d = 1'b1;
        end else begin
          cnt_d       = cnt_inc_s;
          ram_we_d    = 1'b1;
          ram_row_d   = cnt_inc_s[CNT_W-1:ADDR_W];
          ram_col_d   = cnt_inc_s[ADDR_W-1:0];
          ram_wdata_d = CLR_DATA;
          clr_busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      ram_we_q    <= 1'b0;
      ram_row_q   <= {ADDR_W{1'b0}};
      ram_col_q   <= {ADDR_W{1'b0}};
      ram_wdata_q <= {DATA_W{1'b0}};
      pen_gnt_q   <= 1'b0;
      ld_gnt_q    <= 1'b0;
      clr_busy_q  <= 1'b0;
      clr_done_q  <= 1'b0;
      last_row_q  <= {ADDR_W{1'b0}};
      last_col_q  <= {ADDR_W{1'b0}};
`ifdef LED_ARB_RR_EN
      rr_ptr_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ram_we_q    <= ram_we_d;
      ram_row_q   <= ram_row_d;
      ram_col_q   <= ram_col_d;
      ram_wdata_q <= ram_wdata_d;
      pen_gnt_q   <= pen_gnt_d;
      ld_gnt_q    <= ld_gnt_d;
      clr_busy_q  <= clr_busy_d;
      clr_done_q  <= clr_done_d;
      last_row_q  <= last_row_d;
      last_col_q  <= last_col_d;
`ifdef LED_ARB_RR_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  assign ram_we    = ram_we_q;
  assign ram_row   = ram_row_q;
  assign ram_col   = ram_col_q;
  assign ram_wdata = ram_wdata_q;
  assign pen_gnt   = pen_gnt_q;
  assign ld_gnt    = ld_gnt_q;
  assign clr_busy  = clr_busy_q;
  assign clr_done  = clr_done_q;
  assign last_row  = last_row_q;
  assign last_col  = last_col_q;

endmodule

// File: tb/tb_led_wr_arbiter.sv
// Directed self-checking bench for led_wr_arbiter (honours LED_ARB_RR_EN if defined).
module tb_led_wr_arbiter;

  logic       clk;
  logic       rst;
  logic       clr_start;
  logic       clr_busy;
  logic       clr_done;
  logic       pen_req;
  logic [2:0] pen_row;
  logic [2:0] pen_col;
  logic [3:0] pen_data;
  logic       pen_gnt;
  logic       ld_req;
  logic [2:0] ld_row;
  logic [2:0] ld_col;
  logic [3:0] ld_data;
  logic       ld_gnt;
  logic       ram_we;
  logic [2:0] ram_row;
  logic [2:0] ram_col;
  logic [3:0] ram_wdata;
  logic [2:0] last_row;
  logic [2:0] last_col;

  int errors = 0;
  int checks = 0;

  led_wr_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .pen_req   (pen_req),
    .pen_row   (pen_row),
    .pen_col   (pen_col),
    .pen_data  (pen_data),
    .pen_gnt   (pen_gnt),
    .ld_req    (ld_req),
    .ld_row    (ld_row),
    .ld_col    (ld_col),
    .ld_data   (ld_data),
    .ld_gnt    (ld_gnt),
    .ram_we    (ram_we),
    .ram_row   (ram_row),
    .ram_col   (ram_col),
    .ram_wdata (ram_wdata),
    .last_row  (last_row),
    .last_col  (last_col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic prev_we;
    logic exp_ld;
    rst = 1'b1; clr_start = 1'b0;
    pen_req = 1'b0; pen_row = 3'd0; pen_col = 3'd0; pen_data = 4'h0;
    ld_req = 1'b0; ld_row = 3'd0; ld_col = 3'd0; ld_data = 4'h0;
    repeat (3) tick();
    // {we,row,col,wdata,pen_gnt,ld_gnt,busy,done,last_row,last_col}
    check("reset_state", {ram_we, ram_row, ram_col, ram_wdata, pen_gnt, ld_gnt,
                          clr_busy, clr_done, last_row, last_col}, 32'h0);
    rst = 1'b0;
    tick();

    // Single pen write
    pen_req = 1'b1; pen_row = 3'd3; pen_col = 3'd5; pen_data = 4'b1010;
    tick();
    check("pen_write", {ram_we, ram_row, ram_col, ram_wdata, pen_gnt, ld_gnt},
          {1'b1, 3'd3, 3'd5, 4'hA, 1'b1, 1'b0});
    pen_req = 1'b0;
    tick();
    check("pen_after", {ram_we, pen_gnt, last_row, last_col}, {1'b0, 1'b0, 3'd3, 3'd5});

    // Full clear sweep
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      check($sformatf("sweep_%0d", i), {ram_we, clr_busy, clr_done, ram_row, ram_col, ram_wdata},
            {1'b1, 1'b1, 1'b0, i[5:3], i[2:0], 4'h0});
      tick();
    end
    check("sweep_done", {clr_done, clr_busy, ram_we}, {1'b1, 1'b0, 1'b0});
    tick();
    check("sweep_done_pulse", {clr_done, clr_busy, ram_we}, 32'h0);

    // Pen request held across a clear started in the same cycle
    clr_start = 1'b1;
    pen_req = 1'b1; pen_row = 3'd1; pen_col = 3'd2; pen_data = 4'hC;
    tick();
    clr_start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      check($sformatf("held_sweep_%0d", i), {pen_gnt, ram_we, last_row, last_col},
            {1'b0, 1'b1, 3'd3, 3'd5});
      tick();
    end
    check("held_done", {clr_done, pen_gnt, ram_we}, {1'b1, 1'b0, 1'b0});
    tick();
    check("held_turnaround", {clr_done, pen_gnt, ram_we}, 32'h0);
    tick();
    check("held_pen_write", {ram_we, pen_gnt, ram_row, ram_col, ram_wdata},
          {1'b1, 1'b1, 3'd1, 3'd2, 4'hC});
    pen_req = 1'b0;
    tick();
    check("held_last", {last_row, last_col, ram_we}, {3'd1, 3'd2, 1'b0});

    // Both requesters held for 8 grants, starting from reset arbitration state
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    pen_req = 1'b1; pen_row = 3'd2; pen_col = 3'd2; pen_data = 4'h1;
    ld_req  = 1'b1; ld_row  = 3'd6; ld_col  = 3'd7; ld_data  = 4'h6;
    for (int g = 0; g < 8; g++) begin
      tick();
`ifdef LED_ARB_RR_EN
      exp_ld = (g % 2 == 1);
`else
      exp_ld = 1'b0;
`endif
      check($sformatf("both_grant_%0d", g), {ram_we, pen_gnt, ld_gnt, ram_row, ram_col, ram_wdata},
            {1'b1, ~exp_ld, exp_ld, exp_ld ? 3'd6 : 3'd2, exp_ld ? 3'd7 : 3'd2,
             exp_ld ? 4'h6 : 4'h1});
      tick();
      check($sformatf("both_gap_%0d", g), {ram_we, pen_gnt, ld_gnt}, 32'h0);
    end
    pen_req = 1'b0; ld_req = 1'b0;
    tick();

    // Reset at sweep write 20
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (20) tick();
    check("rst_sweep_w20", {ram_we, clr_busy, ram_row, ram_col}, {1'b1, 1'b1, 3'd2, 3'd4});
    rst = 1'b1;
    tick();
    check("rst_sweep_after", {ram_we, clr_busy, clr_done, ram_row, ram_col}, 32'h0);
    rst = 1'b0;
    tick();
    tick();
    check("rst_no_resume", {ram_we, clr_busy, clr_done}, 32'h0);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    check("rst_restart", {ram_we, clr_busy, ram_row, ram_col}, {1'b1, 1'b1, 3'd0, 3'd0});
    tick();
    check("rst_restart_w1", {ram_we, ram_row, ram_col}, {1'b1, 3'd0, 3'd1});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Loader held continuously
    ld_req = 1'b1; ld_row = 3'd4; ld_col = 3'd1; ld_data = 4'h3;
    prev_we = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("ld_held_%0d", i), {ld_gnt, pen_gnt, ram_we, prev_we & ram_we},
            {(i % 2 == 0), 1'b0, (i % 2 == 0), 1'b0});
      prev_we = ram_we;
    end
    ld_req = 1'b0;
    tick();
    check("ld_last", {last_row, last_col, ram_we}, {3'd4, 3'd1, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
